// File: rtl/disp_cmd_if.sv
// disp_cmd_if: groups the display-command byte stream and the cell-buffer
// write port into one interface.
//   cmd_valid / cmd_data / cmd_ready : command byte handshake from the FIFO
//   wr_en / wr_addr / wr_data        : text-cell RAM write port
//   cur_col / cur_row                : cursor position status
// Modports:
//   master : the FIFO side / environment (drives commands, observes outputs)
//   slave  : the decoder (consumes commands, drives the RAM port and cursor)
interface disp_cmd_if #(
  parameter int ADDR_W = 13
);
  logic              cmd_valid;
  logic [7:0]        cmd_data;
  logic              cmd_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [6:0]        cur_col;
  logic [6:0]        cur_row;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, wr_en, wr_addr, wr_data, cur_col, cur_row
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, wr_en, wr_addr, wr_data, cur_col, cur_row
  );
endinterface

// File: rtl/disp_cmd_decoder.sv
// disp_cmd_decoder: interprets the display-command byte stream and writes
// {attr, char} cells into the text-cell buffer RAM.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : disp_cmd_if.slave (command handshake, RAM write port, cursor)
// Optional feature: define DISP_DEC_BACKSPACE_EN to make 0x08 a destructive
// backspace; otherwise 0x08 is ignored like other unused control bytes.
// All outputs are registered; the combinational block computes the next
// value of every register.
module disp_cmd_decoder #(
  parameter int COLS   = 100,
  parameter int ROWS   = 75,
  parameter int ADDR_W = 13
) (
  input  logic      clk,
  input  logic      rst,
  disp_cmd_if.slave bus
);

  localparam int                FW        = ADDR_W + 1;
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [6:0]        LAST_ROW  = 7'(ROWS - 1);
  localparam logic [7:0]        CLAMP_COL = 8'(COLS - 1);
  localparam logic [7:0]        CLAMP_ROW = 8'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  // Fill counter is one bit wider so it can reach the cell count itself.
  localparam logic [FW-1:0]     FILL_END  = FW'(COLS * ROWS);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    ARG_CURSOR_COL = 3'd1,
    ARG_CURSOR_ROW = 3'd2,
    ARG_ATTR       = 3'd3,
    ARG_CHAR       = 3'd4,
    ADDR_CALC      = 3'd5,
    CLEAR          = 3'd6
  } state_t;

  state_t            state, state_next;
  logic [6:0]        col, col_next;
  logic [6:0]        row, row_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [7:0]        attr, attr_next;
  logic [FW-1:0]     fill, fill_next;
  logic              ready, ready_next;
  logic              wen, wen_next;
  logic [ADDR_W-1:0] waddr, waddr_next;
  logic [15:0]       wdata, wdata_next;

  logic              accept;
  logic [6:0]        row_inc;
  logic [6:0]        adv_col;
  logic [6:0]        adv_row;
  logic [ADDR_W-1:0] adv_addr;

  assign accept   = bus.cmd_valid && ready;
  assign row_inc  = (row == LAST_ROW) ? 7'd0 : row + 7'd1;
  // Cursor after a character write: step right, wrap to next row, wrap screen.
  assign adv_col  = (col == LAST_COL) ? 7'd0 : col + 7'd1;
  assign adv_row  = (col == LAST_COL) ? row_inc : row;
  assign adv_addr = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);

  assign bus.cmd_ready = ready;
  assign bus.wr_en     = wen;
  assign bus.wr_addr   = waddr;
  assign bus.wr_data   = wdata;
  assign bus.cur_col   = col;
  assign bus.cur_row   = row;

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col   <= 7'd0;
      row   <= 7'd0;
      addr  <= '0;
      attr  <= 8'h0F;
      fill  <= '0;
      ready <= 1'b1;
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= 16'h0000;
    end else begin
      state <= state_next;
      col   <= col_next;
      row   <= row_next;
      addr  <= addr_next;
      attr  <= attr_next;
      fill  <= fill_next;
      ready <= ready_next;
      wen   <= wen_next;
      waddr <= waddr_next;
      wdata <= wdata_next;
    end
  end

  // Next-state, cursor, attribute and write-port computation.
  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    addr_next  = addr;
    attr_next  = attr;
    fill_next  = fill;
    wen_next   = 1'b0;
    waddr_next = waddr;
    wdata_next = wdata;

    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_data >= 8'h20) begin
            wen_next   = 1'b1;
            waddr_next = addr;
            wdata_next = {attr, bus.cmd_data};
            col_next   = adv_col;
            row_next   = adv_row;
            addr_next  = adv_addr;
          end else begin
            case (bus.cmd_data)
              8'h01: state_next = ARG_CURSOR_COL;
              8'h02: state_next = ARG_ATTR;
              8'h03: begin
                // First fill write is issued on acceptance; the sweep
                // continues from cell 1 while in CLEAR.
                state_next = CLEAR;
                wen_next   = 1'b1;
                waddr_next = '0;
                wdata_next = {attr, 8'h20};
                fill_next  = FW'(1);
              end
              8'h04: state_next = ARG_CHAR;
              8'h0A: begin
                col_next  = 7'd0;
                row_next  = row_inc;
                addr_next = ADDR_W'(row_inc) * COLS_A;
              end
              8'h0D: begin
                col_next  = 7'd0;
                addr_next = ADDR_W'(row) * COLS_A;
              end
`ifdef DISP_DEC_BACKSPACE_EN
              8'h08: begin
                if (col == 7'd0) begin
                  col_next = LAST_COL;
                  row_next = (row == 7'd0) ? LAST_ROW : row - 7'd1;
                end else begin
                  col_next = col - 7'd1;
                end
                addr_next  = (addr == '0) ? LAST_ADDR : addr - ADDR_W'(1);
                wen_next   = 1'b1;
                waddr_next = (addr == '0) ? LAST_ADDR : addr - ADDR_W'(1);
                wdata_next = {attr, 8'h20};
              end
`endif
              default: state_next = IDLE;
            endcase
          end
        end else begin
          state_next = IDLE;
        end
      end

      ARG_CURSOR_COL: begin
        if (accept) begin
          col_next   = (bus.cmd_data > CLAMP_COL) ? LAST_COL : bus.cmd_data[6:0];
          state_next = ARG_CURSOR_ROW;
        end else begin
          state_next = ARG_CURSOR_COL;
        end
      end

      ARG_CURSOR_ROW: begin
        if (accept) begin
          row_next   = (bus.cmd_data > CLAMP_ROW) ? LAST_ROW : bus.cmd_data[6:0];
          state_next = ADDR_CALC;
        end else begin
          state_next = ARG_CURSOR_ROW;
        end
      end

      ADDR_CALC: begin
        addr_next  = ADDR_W'(row) * COLS_A + ADDR_W'(col);
        state_next = IDLE;
      end

      ARG_ATTR: begin
        if (accept) begin
          attr_next  = bus.cmd_data;
          state_next = IDLE;
        end else begin
          state_next = ARG_ATTR;
        end
      end

      ARG_CHAR: begin
        if (accept) begin
          wen_next   = 1'b1;
          waddr_next = addr;
          wdata_next = {attr, bus.cmd_data};
          col_next   = adv_col;
          row_next   = adv_row;
          addr_next  = adv_addr;
          state_next = IDLE;
        end else begin
          state_next = ARG_CHAR;
        end
      end

      CLEAR: begin
        // The cycle with fill == cell count issues no write; it keeps
        // cmd_ready low until the cycle after the last write is visible.
        if (fill == FILL_END) begin
          state_next = IDLE;
          col_next   = 7'd0;
          row_next   = 7'd0;
          addr_next  = '0;
          fill_next  = '0;
        end else begin
          wen_next   = 1'b1;
          waddr_next = fill[ADDR_W-1:0];
          wdata_next = {attr, 8'h20};
          fill_next  = fill + FW'(1);
        end
      end

      default: state_next = IDLE;
    endcase

    ready_next = !((state_next == ADDR_CALC) || (state_next == CLEAR));
  end

endmodule

// File: tb/tb_disp_cmd_decoder.sv
// tb_disp_cmd_decoder: directed self-checking bench for disp_cmd_decoder.
// Each task drives one scenario and compares outputs against hand-computed
// values. Outputs are sampled 1 time unit after the rising edge.
module tb_disp_cmd_decoder;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  disp_cmd_if #(.ADDR_W(13)) bus ();

  disp_cmd_decoder #(.COLS(100), .ROWS(75), .ADDR_W(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cmd_ready, presents one byte for one cycle, and
  // returns 1 unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); end
    vectors++; if (bus.wr_addr !== 13'd0) begin miscompares++; $display("FAIL rst_wr_addr: got %0d want 0", bus.wr_addr); end
    vectors++; if (bus.wr_data !== 16'h0000) begin miscompares++; $display("FAIL rst_wr_data: got %h want 0000", bus.wr_data); end
    vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", bus.cmd_ready); end
    vectors++; if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd0) begin miscompares++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", bus.cur_col, bus.cur_row); end
  endtask

  task automatic test_char_write();
    send_byte(8'h41);
    vectors++; if (bus.wr_en !== 1'b1) begin miscompares++; $display("FAIL char_wr_en: got %b want 1", bus.wr_en); end
    vectors++; if (bus.wr_addr !== 13'd0) begin miscompares++; $display("FAIL char_addr: got %0d want 0", bus.wr_addr); end
    vectors++; if (bus.wr_data !== 16'h0F41) begin miscompares++; $display("FAIL char_data: got %h want 0f41", bus.wr_data); end
    vectors++; if (bus.cur_col !== 7'd1) begin miscompares++; $display("FAIL char_col: got %0d want 1", bus.cur_col); end
    tick();
    vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL char_pulse_width: got %b want 0", bus.wr_en); end
  endtask

  task automatic test_set_cursor();
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h02);
    vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL addr_calc_ready: got %b want 0", bus.cmd_ready); end
    tick();
    vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL addr_calc_done: got %b want 1", bus.cmd_ready); end
    send_byte(8'h42);
    vectors++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'd205) begin miscompares++; $display("FAIL cursor_addr: got en=%b addr=%0d want en=1 addr=205", bus.wr_en, bus.wr_addr); end
    vectors++; if (bus.wr_data !== 16'h0F42) begin miscompares++; $display("FAIL cursor_data: got %h want 0f42", bus.wr_data); end
    vectors++; if (bus.cur_col !== 7'd6 || bus.cur_row !== 7'd2) begin miscompares++; $display("FAIL cursor_pos: got (%0d,%0d) want (6,2)", bus.cur_col, bus.cur_row); end
  endtask

  task automatic test_screen_wrap();
    send_byte(8'h02); send_byte(8'h1E);
    send_byte(8'h01); send_byte(8'h63); send_byte(8'h4A);
    send_byte(8'h5A);
    vectors++; if (bus.wr_addr !== 13'd7499 || bus.wr_data !== 16'h1E5A) begin miscompares++; $display("FAIL wrap_write: got addr=%0d data=%h want 7499 1e5a", bus.wr_addr, bus.wr_data); end
    vectors++; if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd0) begin miscompares++; $display("FAIL wrap_cursor: got (%0d,%0d) want (0,0)", bus.cur_col, bus.cur_row); end
    send_byte(8'h41);
    vectors++; if (bus.wr_addr !== 13'd0 || bus.wr_data !== 16'h1E41) begin miscompares++; $display("FAIL wrap_addr_next: got addr=%0d data=%h want 0 1e41", bus.wr_addr, bus.wr_data); end
  endtask

  task automatic test_clear();
    int writes;
    int low;
    int bad;
    int n;
    writes = 0; low = 0; bad = 0; n = 0;
    send_byte(8'h03);
    while (bus.cmd_ready !== 1'b1 && n < 8000) begin
      low++;
      if (bus.wr_en === 1'b1) begin
        if (bus.wr_addr !== 13'(writes) || bus.wr_data !== 16'h1E20) bad++;
        writes++;
      end else begin
        bad++;
      end
      // Stray byte while busy must be dropped.
      bus.cmd_valid = (n == 50);
      bus.cmd_data  = 8'h41;
      tick();
      n++;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL clear_timeout: cmd_ready=%b want 1", bus.cmd_ready); end
    vectors++; if (low !== 7500) begin miscompares++; $display("FAIL clear_busy_cycles: got %0d want 7500", low); end
    vectors++; if (writes !== 7500) begin miscompares++; $display("FAIL clear_writes: got %0d want 7500", writes); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL clear_sequence: got %0d bad cycles want 0", bad); end
    vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL clear_end_wr_en: got %b want 0", bus.wr_en); end
    vectors++; if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd0) begin miscompares++; $display("FAIL clear_cursor: got (%0d,%0d) want (0,0)", bus.cur_col, bus.cur_row); end
    send_byte(8'h41);
    vectors++; if (bus.wr_addr !== 13'd0 || bus.wr_data !== 16'h1E41) begin miscompares++; $display("FAIL clear_addr_home: got addr=%0d data=%h want 0 1e41", bus.wr_addr, bus.wr_data); end
  endtask

  task automatic test_controls();
    send_byte(8'h0A);
    vectors++; if (bus.wr_en !== 1'b0 || bus.cur_col !== 7'd0 || bus.cur_row !== 7'd1) begin miscompares++; $display("FAIL lf: got en=%b (%0d,%0d) want en=0 (0,1)", bus.wr_en, bus.cur_col, bus.cur_row); end
    send_byte(8'h43);
    vectors++; if (bus.wr_addr !== 13'd100 || bus.wr_data !== 16'h1E43) begin miscompares++; $display("FAIL lf_addr: got addr=%0d data=%h want 100 1e43", bus.wr_addr, bus.wr_data); end
    send_byte(8'h0D);
    vectors++; if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd1) begin miscompares++; $display("FAIL cr: got (%0d,%0d) want (0,1)", bus.cur_col, bus.cur_row); end
    send_byte(8'h07);
    vectors++; if (bus.wr_en !== 1'b0 || bus.cur_col !== 7'd0) begin miscompares++; $display("FAIL ignored_ctrl: got en=%b col=%0d want en=0 col=0", bus.wr_en, bus.cur_col); end
    send_byte(8'h44);
    vectors++; if (bus.wr_addr !== 13'd100 || bus.cur_col !== 7'd1) begin miscompares++; $display("FAIL cr_addr: got addr=%0d col=%0d want 100 1", bus.wr_addr, bus.cur_col); end
  endtask

  task automatic test_clamp_raw();
    send_byte(8'h01); send_byte(8'hC8);
    vectors++; if (bus.cur_col !== 7'd99) begin miscompares++; $display("FAIL clamp_col: got %0d want 99", bus.cur_col); end
    send_byte(8'hFF);
    vectors++; if (bus.cur_row !== 7'd74) begin miscompares++; $display("FAIL clamp_row: got %0d want 74", bus.cur_row); end
    send_byte(8'h04);
    vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL raw_prefix: got en=%b want 0", bus.wr_en); end
    send_byte(8'h0A);
    vectors++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'd7499 || bus.wr_data !== 16'h1E0A) begin miscompares++; $display("FAIL raw_write: got en=%b addr=%0d data=%h want 1 7499 1e0a", bus.wr_en, bus.wr_addr, bus.wr_data); end
    vectors++; if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd0) begin miscompares++; $display("FAIL raw_cursor: got (%0d,%0d) want (0,0)", bus.cur_col, bus.cur_row); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    n = 0;
    send_byte(8'h02); send_byte(8'h55);
    send_byte(8'h03);
    while (!(bus.wr_en === 1'b1 && bus.wr_addr === 13'd100) && n < 400) begin
      tick();
      n++;
    end
    vectors++; if (bus.wr_addr !== 13'd100) begin miscompares++; $display("FAIL clear_reach_100: got %0d want 100", bus.wr_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (bus.wr_en !== 1'b0 || bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL midclear_reset: got en=%b ready=%b want 0 1", bus.wr_en, bus.cmd_ready); end
    send_byte(8'h41);
    vectors++; if (bus.wr_addr !== 13'd0 || bus.wr_data !== 16'h0F41) begin miscompares++; $display("FAIL midclear_attr: got addr=%0d data=%h want 0 0f41", bus.wr_addr, bus.wr_data); end
  endtask

  task automatic test_backspace();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_byte(8'h08);
`ifdef DISP_DEC_BACKSPACE_EN
    vectors++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'd7499 || bus.wr_data !== 16'h0F20) begin miscompares++; $display("FAIL bs_write: got en=%b addr=%0d data=%h want 1 7499 0f20", bus.wr_en, bus.wr_addr, bus.wr_data); end
    vectors++; if (bus.cur_col !== 7'd99 || bus.cur_row !== 7'd74) begin miscompares++; $display("FAIL bs_cursor: got (%0d,%0d) want (99,74)", bus.cur_col, bus.cur_row); end
`else
    vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL bs_ignored_en: got %b want 0", bus.wr_en); end
    vectors++; if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd0) begin miscompares++; $display("FAIL bs_ignored_cursor: got (%0d,%0d) want (0,0)", bus.cur_col, bus.cur_row); end
`endif
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    test_reset();
    test_char_write();
    test_set_cursor();
    test_screen_wrap();
    test_clear();
    test_controls();
    test_clamp_raw();
    test_reset_mid_clear();
    test_backspace();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
